// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, instruction length
// encoding and the LEN(op) decoder reused by decode.
package cpu_pkg;

  // Instruction length in bytes, 1..3 (0 only out of reset).
  typedef logic [1:0] ins_len_t;

  // Fetch FSM state encoding.
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_FETCH = 2'd0;
  localparam fetch_state_t S_WAIT  = 2'd1;
  localparam fetch_state_t S_HOLD  = 2'd2;

  localparam ins_len_t LEN_1 = 2'd1;
  localparam ins_len_t LEN_2 = 2'd2;
  localparam ins_len_t LEN_3 = 2'd3;

  // Length is fully determined by the two opcode MSBs.
  function automatic ins_len_t ins_len_f(
    input logic [7:0] op
  );
    ins_len_t len;
    unique case (1'b1)
      (op[7:6] == 2'b00): len = LEN_1;
      (op[7:6] == 2'b01): len = LEN_2;
      default:            len = LEN_3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: LSU fetch port, redirect and decode handshake.
// master = fetch unit side, slave = LSU/decode environment side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [15:0] lsu_a;
  logic        lsu_re;
  logic        lsu_busy;
  logic [7:0]  lsu_q0;
  logic [7:0]  lsu_q1;
  logic [7:0]  lsu_q2;

  logic        redirect;
  logic [15:0] redirect_pc;

  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_op;
  logic [7:0]  ins_b1;
  logic [7:0]  ins_b2;
  ins_len_t    ins_len;
  logic [15:0] ins_pc;

  modport master (
    output lsu_a,
    output lsu_re,
    input  lsu_busy,
    input  lsu_q0,
    input  lsu_q1,
    input  lsu_q2,
    input  redirect,
    input  redirect_pc,
    output ins_valid,
    input  ins_ready,
    output ins_op,
    output ins_b1,
    output ins_b2,
    output ins_len,
    output ins_pc
  );

  modport slave (
    input  lsu_a,
    input  lsu_re,
    output lsu_busy,
    output lsu_q0,
    output lsu_q1,
    output lsu_q2,
    output redirect,
    output redirect_pc,
    input  ins_valid,
    output ins_ready,
    input  ins_op,
    input  ins_b1,
    input  ins_b2,
    input  ins_len,
    input  ins_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Variable-length (1..3 byte) instruction fetch: FETCH/WAIT/HOLD FSM
// issuing reads to the shared LSU and presenting one instruction to decode.
// Ports: clk, rst (sync, active-low); lsu_a/lsu_re/lsu_busy/lsu_q0..2 LSU
// port; redirect/redirect_pc flush; ins_* valid/ready decode output.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lsu_a,
  output logic        lsu_re,
  input  logic        lsu_busy,
  input  logic [7:0]  lsu_q0,
  input  logic [7:0]  lsu_q1,
  input  logic [7:0]  lsu_q2,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_op,
  output logic [7:0]  ins_b1,
  output logic [7:0]  ins_b2,
  output ins_len_t    ins_len,
  output logic [15:0] ins_pc
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [15:0]  pc_q;
  logic [15:0]  pc_d;
  logic [7:0]   op_q;
  logic [7:0]   op_d;
  logic [7:0]   b1_q;
  logic [7:0]   b1_d;
  logic [7:0]   b2_q;
  logic [7:0]   b2_d;
  ins_len_t     len_q;
  ins_len_t     len_d;
  logic [15:0]  ipc_q;
  logic [15:0]  ipc_d;

  logic         in_fetch;
  logic         in_wait;
  logic         in_hold;
  logic         issue;
  ins_len_t     cap_len;

  always_comb begin
    in_fetch = (state_q == S_FETCH);
    in_wait  = (state_q == S_WAIT);
    in_hold  = (state_q == S_HOLD);
  end

  // A read goes out from FETCH, or from HOLD once decode takes the
  // current instruction; the LSU and a flush both block it.
  always_comb begin
    issue = rst & ~redirect & ~lsu_busy
          & (in_fetch | (in_hold & ins_ready));
  end

  assign lsu_re    = issue;
  assign lsu_a     = pc_q;
  assign ins_valid = in_hold;
  assign ins_op    = op_q;
  assign ins_b1    = b1_q;
  assign ins_b2    = b2_q;
  assign ins_len   = len_q;
  assign ins_pc    = ipc_q;

  assign cap_len = ins_len_f(lsu_q0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    if (redirect) begin
      // Flush: drop any in-flight response, restart at the target.
      state_d = S_FETCH;
      pc_d    = redirect_pc;
    end else begin
      unique case (1'b1)
        in_fetch: begin
          if (!lsu_busy) state_d = S_WAIT;
        end
        in_wait: begin
          op_d    = lsu_q0;
          b1_d    = lsu_q1;
          b2_d    = lsu_q2;
          len_d   = cap_len;
          ipc_d   = pc_q;
          pc_d    = pc_q + {14'd0, cap_len};
          state_d = S_HOLD;
        end
        in_hold: begin
          if (ins_ready) begin
            state_d = lsu_busy ? S_FETCH : S_WAIT;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      op_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      len_q   <= 2'd0;
      ipc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory-backed LSU model, an
// architectural-PC reference model checked every cycle, plus directed cases.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if ifc();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_a       (ifc.lsu_a),
    .lsu_re      (ifc.lsu_re),
    .lsu_busy    (ifc.lsu_busy),
    .lsu_q0      (ifc.lsu_q0),
    .lsu_q1      (ifc.lsu_q1),
    .lsu_q2      (ifc.lsu_q2),
    .redirect    (ifc.redirect),
    .redirect_pc (ifc.redirect_pc),
    .ins_valid   (ifc.ins_valid),
    .ins_ready   (ifc.ins_ready),
    .ins_op      (ifc.ins_op),
    .ins_b1      (ifc.ins_b1),
    .ins_b2      (ifc.ins_b2),
    .ins_len     (ifc.ins_len),
    .ins_pc      (ifc.ins_pc)
  );

  bit [7:0] mem [0:65535];

  logic [15:0] lat_a = 16'h0;
  logic        resp_v = 1'b0;
  logic [15:0] lat_a1;
  logic [15:0] lat_a2;

  always @(posedge clk) begin
    resp_v <= ifc.lsu_re;
    if (ifc.lsu_re) lat_a <= ifc.lsu_a;
  end

  always_comb begin
    lat_a1 = lat_a + 16'd1;
    lat_a2 = lat_a + 16'd2;
    ifc.lsu_q0 = resp_v ? mem[lat_a]  : 8'hEE;
    ifc.lsu_q1 = resp_v ? mem[lat_a1] : 8'hEE;
    ifc.lsu_q2 = resp_v ? mem[lat_a2] : 8'hEE;
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int len_of(bit [7:0] op);
    if (op < 8'd64) return 1;
    if (op < 8'd128) return 2;
    return 3;
  endfunction

  // Reference model: the architectural PC of the next instruction decode
  // should see; instruction bytes come straight from memory.
  logic [15:0] pc_m = 16'h0;
  logic [15:0] m_a1;
  logic [15:0] m_a2;
  int          m_len;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst) begin
        chk("m_rst_no_re", 32'(ifc.lsu_re), 32'd0);
        pc_m = 16'h0000;
      end else begin
        if (ifc.redirect || ifc.lsu_busy)
          chk("m_blocked_no_re", 32'(ifc.lsu_re), 32'd0);
        if (ifc.ins_valid) begin
          m_a1  = pc_m + 16'd1;
          m_a2  = pc_m + 16'd2;
          m_len = len_of(mem[pc_m]);
          chk("m_pc", 32'(ifc.ins_pc), 32'(pc_m));
          chk("m_op", 32'(ifc.ins_op), 32'(mem[pc_m]));
          chk("m_b1", 32'(ifc.ins_b1), 32'(mem[m_a1]));
          chk("m_b2", 32'(ifc.ins_b2), 32'(mem[m_a2]));
          chk("m_len", 32'(ifc.ins_len), 32'(m_len));
          if (!ifc.ins_ready) begin
            chk("m_stall_no_re", 32'(ifc.lsu_re), 32'd0);
          end else begin
            pc_m = pc_m + 16'(m_len);
            if (ifc.lsu_re)
              chk("m_next_a", 32'(ifc.lsu_a), 32'(pc_m));
          end
        end else if (ifc.lsu_re) begin
          chk("m_fetch_a", 32'(ifc.lsu_a), 32'(pc_m));
        end
        if (ifc.redirect) pc_m = ifc.redirect_pc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          n;
  int          cyc  [3];
  logic [15:0] pcs  [3];
  logic [1:0]  lens [3];

  initial begin
    rst             = 1'b0;
    ifc.ins_ready   = 1'b0;
    ifc.lsu_busy    = 1'b0;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 16'h0;
    mem[16'h0010] = 8'h40; mem[16'h0011] = 8'hAA;
    mem[16'h0012] = 8'h80; mem[16'h0013] = 8'hB1;
    mem[16'h0014] = 8'hB2; mem[16'h0015] = 8'h00;
    mem[16'h0016] = 8'h01; mem[16'h0017] = 8'h02;
    mem[16'h0018] = 8'hC0; mem[16'h0019] = 8'h11;
    mem[16'h001A] = 8'h22;
    mem[16'h1234] = 8'h41; mem[16'h1235] = 8'h55;
    mem[16'h1236] = 8'h66;
    mem[16'hFFFF] = 8'h80;
    mem[16'h0002] = 8'h9A;

    tick();
    mon_en = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(ifc.ins_valid), 32'd0);
    chk("rst_op", 32'(ifc.ins_op), 32'd0);
    chk("rst_len", 32'(ifc.ins_len), 32'd0);
    chk("rst_pc", 32'(ifc.ins_pc), 32'd0);
    chk("rst_re", 32'(ifc.lsu_re), 32'd0);

    // Reset release, single-byte op at 0000.
    rst = 1'b1;
    ifc.ins_ready = 1'b1;
    #1;
    chk("t1_re_c0", 32'(ifc.lsu_re), 32'd1);
    chk("t1_a_c0", 32'(ifc.lsu_a), 32'h0000);
    tick();
    chk("t1_valid_c1", 32'(ifc.ins_valid), 32'd0);
    chk("t1_re_c1", 32'(ifc.lsu_re), 32'd0);
    tick();
    chk("t1_valid_c2", 32'(ifc.ins_valid), 32'd1);
    chk("t1_pc_c2", 32'(ifc.ins_pc), 32'h0000);
    chk("t1_len_c2", 32'(ifc.ins_len), 32'd1);
    chk("t1_next_a", 32'(ifc.lsu_a), 32'h0001);
    chk("t1_next_re", 32'(ifc.lsu_re), 32'd1);

    // Redirect on the accepting cycle; stream from 0010.
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'h0010;
    #1;
    chk("t1_redir_no_re", 32'(ifc.lsu_re), 32'd0);
    tick();
    ifc.redirect = 1'b0;
    #1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (n < 3) begin
        if (ifc.ins_valid && ifc.ins_ready) begin
          cyc[n]  = c;
          pcs[n]  = ifc.ins_pc;
          lens[n] = ifc.ins_len;
          n++;
        end
        if (n < 3) tick();
      end
    end
    chk("t2_count", 32'(n), 32'd3);
    chk("t2_pc0", 32'(pcs[0]), 32'h0010);
    chk("t2_pc1", 32'(pcs[1]), 32'h0012);
    chk("t2_pc2", 32'(pcs[2]), 32'h0015);
    chk("t2_len0", 32'(lens[0]), 32'd2);
    chk("t2_len1", 32'(lens[1]), 32'd3);
    chk("t2_len2", 32'(lens[2]), 32'd1);
    chk("t2_gap1", 32'(cyc[1] - cyc[0]), 32'd2);
    chk("t2_gap2", 32'(cyc[2] - cyc[1]), 32'd2);

    // Decode stall for 5 cycles in HOLD at 0016.
    tick();
    ifc.ins_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", 32'(ifc.ins_valid), 32'd1);
      chk("t3_pc", 32'(ifc.ins_pc), 32'h0016);
      chk("t3_op", 32'(ifc.ins_op), 32'h01);
      chk("t3_b1", 32'(ifc.ins_b1), 32'h02);
      chk("t3_b2", 32'(ifc.ins_b2), 32'hC0);
      chk("t3_len", 32'(ifc.ins_len), 32'd1);
      chk("t3_re", 32'(ifc.lsu_re), 32'd0);
      tick();
    end
    ifc.ins_ready = 1'b1;
    #1;
    chk("t3_rel_re", 32'(ifc.lsu_re), 32'd1);
    chk("t3_rel_a", 32'(ifc.lsu_a), 32'h0017);

    // LSU busy: HOLD->FETCH, then 3 busy FETCH cycles.
    tick();
    tick();
    chk("t4_hold_pc", 32'(ifc.ins_pc), 32'h0017);
    ifc.lsu_busy = 1'b1;
    #1;
    chk("t4_hold_busy_re", 32'(ifc.lsu_re), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_busy_re", 32'(ifc.lsu_re), 32'd0);
      chk("t4_busy_valid", 32'(ifc.ins_valid), 32'd0);
      chk("t4_busy_a", 32'(ifc.lsu_a), 32'h0018);
      tick();
    end
    ifc.lsu_busy = 1'b0;
    #1;
    chk("t4_issue_re", 32'(ifc.lsu_re), 32'd1);
    chk("t4_issue_a", 32'(ifc.lsu_a), 32'h0018);

    // Redirect during WAIT: C0 bytes at 0018 must be dropped.
    tick();
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'h1234;
    #1;
    chk("t5_wait_re", 32'(ifc.lsu_re), 32'd0);
    chk("t5_wait_valid", 32'(ifc.ins_valid), 32'd0);
    tick();
    ifc.redirect = 1'b0;
    #1;
    chk("t5_valid0", 32'(ifc.ins_valid), 32'd0);
    chk("t5_re", 32'(ifc.lsu_re), 32'd1);
    chk("t5_a", 32'(ifc.lsu_a), 32'h1234);
    tick();
    chk("t5_valid1", 32'(ifc.ins_valid), 32'd0);
    tick();
    chk("t5_valid2", 32'(ifc.ins_valid), 32'd1);
    chk("t5_pc", 32'(ifc.ins_pc), 32'h1234);
    chk("t5_op", 32'(ifc.ins_op), 32'h41);

    // Redirect to FFFF while stalled; PC wraps past 16'hFFFF.
    ifc.ins_ready   = 1'b0;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'hFFFF;
    #1;
    chk("t6_redir_re", 32'(ifc.lsu_re), 32'd0);
    tick();
    ifc.redirect  = 1'b0;
    ifc.ins_ready = 1'b1;
    #1;
    chk("t6_re", 32'(ifc.lsu_re), 32'd1);
    chk("t6_a", 32'(ifc.lsu_a), 32'hFFFF);
    tick();
    tick();
    chk("t6_valid", 32'(ifc.ins_valid), 32'd1);
    chk("t6_pc", 32'(ifc.ins_pc), 32'hFFFF);
    chk("t6_op", 32'(ifc.ins_op), 32'h80);
    chk("t6_len", 32'(ifc.ins_len), 32'd3);
    chk("t6_next_re", 32'(ifc.lsu_re), 32'd1);
    chk("t6_next_a", 32'(ifc.lsu_a), 32'h0002);

    // Reset during WAIT: response at 0002 is dropped.
    tick();
    rst = 1'b0;
    #1;
    chk("t7_rst_re", 32'(ifc.lsu_re), 32'd0);
    tick();
    chk("t7_valid", 32'(ifc.ins_valid), 32'd0);
    chk("t7_op", 32'(ifc.ins_op), 32'd0);
    chk("t7_pc", 32'(ifc.ins_pc), 32'd0);
    chk("t7_len", 32'(ifc.ins_len), 32'd0);
    rst = 1'b1;
    #1;
    chk("t7_re", 32'(ifc.lsu_re), 32'd1);
    chk("t7_a", 32'(ifc.lsu_a), 32'h0000);
    for (int i = 0; i < 8; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
